// File: rtl/std_dffpipe_sr.sv
// DEPTH-stage register pipeline with valid/ready handshake, flush and occupancy count.
// Stalls propagate backward through a capacity chain, so bubbles collapse and idle stages keep accepting.
module std_dffpipe_sr #(
    parameter int                   DFF_WIDTH       = 1,
    parameter int                   DEPTH           = 2,
    parameter logic [DFF_WIDTH-1:0] DFF_RESET_VALUE = '0,
    parameter int                   CNT_WIDTH       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DFF_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DFF_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] count
);

    logic [DEPTH:0]         cap;
    logic [DEPTH-1:0]       v_all;
    logic [DFF_WIDTH-1:0]   d_all [DEPTH];
    logic                   accept;

    // cap[i]: stage i can take a word this cycle, either because it is empty
    // or because everything ahead of it is moving.
    always_comb begin
        cap        = '0;
        cap[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cap[i] = ~v_all[i] | cap[i+1];
        end
    end

    assign in_ready  = cap[0] & ~flush & ~reset;
    assign accept    = in_valid & in_ready;
    assign out_valid = v_all[DEPTH-1];
    assign out_data  = d_all[DEPTH-1];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic                 src_valid;
            logic [DFF_WIDTH-1:0] src_data;
            logic                 v_reg;
            logic [DFF_WIDTH-1:0] d_reg;

            if (gi == 0) begin : g_head
                assign src_valid = accept;
                assign src_data  = in_data;
            end else begin : g_body
                assign src_valid = v_all[gi-1];
                assign src_data  = d_all[gi-1];
            end

            // Data only moves with a valid word, so a draining stage keeps its stale value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_reg <= 1'b0;
                    d_reg <= DFF_RESET_VALUE;
                end else if (flush) begin
                    v_reg <= 1'b0;
                end else if (cap[gi]) begin
                    v_reg <= src_valid;
                    if (src_valid) begin
                        d_reg <= src_data;
                    end
                end
            end

            assign v_all[gi] = v_reg;
            assign d_all[gi] = d_reg;
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_WIDTH'(v_all[i]);
        end
    end

endmodule

// File: tb/tb_std_dffpipe_sr.sv
// Randomised and directed bench for std_dffpipe_sr against a queue-of-words model
// where each word carries its stage position and slides forward when the slot ahead frees.
module tb_std_dffpipe_sr;

    localparam int            W  = 8;
    localparam int            D  = 3;
    localparam logic [W-1:0]  RV = 8'hA5;
    localparam int            CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    std_dffpipe_sr #(
        .DFF_WIDTH      (W),
        .DEPTH          (D),
        .DFF_RESET_VALUE(RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: oldest word first, each with its stage index.
    logic [W-1:0] mq_d[$];
    int           mq_p[$];
    logic [W-1:0] last_out;
    int           n_acc, n_drn, n_fl;
    bit           model_ok = 1'b0;

    logic         c_ir, c_ov;
    logic [W-1:0] c_od;
    int           c_cnt;

    function automatic bit m_in_ready();
        return !reset && !flush && ((mq_d.size() < D) || out_ready);
    endfunction

    function automatic bit m_out_valid();
        return (mq_p.size() > 0) && (mq_p[0] == D - 1);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        cmp("in_ready",  32'(in_ready),  32'(m_in_ready()));
        cmp("out_valid", 32'(out_valid), 32'(m_out_valid()));
        cmp("out_data",  32'(out_data),  32'(last_out));
        cmp("count",     32'(count),     32'(mq_d.size()));
        cmp("ledger",    32'(count),     32'(n_acc - n_drn - n_fl));
    endtask

    task automatic model_step();
        bit acc;
        int lim;
        int np;
        acc = in_valid && m_in_ready();
        if (reset) begin
            mq_d.delete(); mq_p.delete();
            last_out = RV;
            n_acc = 0; n_drn = 0; n_fl = 0;
            model_ok = 1'b1;
        end else begin
            if (m_out_valid() && out_ready) begin
                void'(mq_d.pop_front()); void'(mq_p.pop_front());
                n_drn++;
            end
            if (flush) begin
                n_fl += mq_d.size();
                mq_d.delete(); mq_p.delete();
            end else begin
                lim = D;
                for (int k = 0; k < mq_p.size(); k++) begin
                    np = (mq_p[k] + 1 < lim - 1) ? mq_p[k] + 1 : lim - 1;
                    if (np == D - 1 && mq_p[k] != D - 1) last_out = mq_d[k];
                    mq_p[k] = np;
                    lim = np;
                end
                if (acc) begin
                    mq_d.push_back(in_data);
                    mq_p.push_back(0);
                    n_acc++;
                    if (D == 1) last_out = in_data;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit fl, input bit iv, input logic [W-1:0] id, input bit ordy);
        @(negedge clk);
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        c_ir = in_ready; c_ov = out_valid; c_od = out_data; c_cnt = int'(count);
        if (model_ok) check_cycle();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
    endtask

    initial begin
        int peak;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Back-to-back stream with out_ready held high.
        do_reset();
        peak = 0;
        for (int t = 0; t < 8; t++) begin
            step(0, 0, t < 3, 8'(8'h11 * (t + 1)), 1);
            if (c_cnt > peak) peak = c_cnt;
            if (t == 2) cmp("t1_early", 32'(c_ov), 32'd0);
            if (t >= 3 && t <= 5) begin
                cmp("t1_valid", 32'(c_ov), 32'd1);
                cmp("t1_data",  32'(c_od), 32'(8'h11 * (t - 2)));
            end
        end
        cmp("t1_peak", 32'(peak), 32'd3);

        // Fill with downstream stalled, then release.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            step(0, 0, 1, (t < 3) ? 8'(8'hA0 + t) : 8'hA3, 0);
            if (t >= 3) begin
                cmp("t2_full_ready", 32'(c_ir),  32'd0);
                cmp("t2_full_count", 32'(c_cnt), 32'd3);
                cmp("t2_stable",     32'(c_od),  32'hA0);
            end
        end
        step(0, 0, 1, 8'hA3, 1);
        cmp("t2_drain_fill", 32'(c_ir), 32'd1);
        for (int t = 0; t < 6; t++) step(0, 0, 0, 8'h00, 1);

        // Bubble collapse: two words separated by idle cycles.
        do_reset();
        step(0, 0, 1, 8'hC1, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'hC2, 0);
        step(0, 0, 0, 8'h00, 0);
        cmp("t3_count", 32'(c_cnt), 32'd2);
        cmp("t3_ready", 32'(c_ir),  32'd1);
        cmp("t3_head",  32'(c_od),  32'hC1);
        for (int t = 0; t < 5; t++) step(0, 0, 0, 8'h00, 1);

        // Flush with a full pipe and a word offered.
        do_reset();
        for (int t = 0; t < 3; t++) step(0, 0, 1, 8'(8'h31 + t), 0);
        step(0, 1, 1, 8'hEE, 0);
        cmp("t4_flush_ready", 32'(c_ir),  32'd0);
        cmp("t4_flush_count", 32'(c_cnt), 32'd3);
        step(0, 0, 1, 8'h5A, 1);
        cmp("t4_after_count", 32'(c_cnt), 32'd0);
        cmp("t4_after_valid", 32'(c_ov),  32'd0);
        cmp("t4_after_ready", 32'(c_ir),  32'd1);
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 8'h00, 1);
            if (j == 2) begin
                cmp("t4_new_valid", 32'(c_ov), 32'd1);
                cmp("t4_new_data",  32'(c_od), 32'h5A);
            end
        end

        // Reset mid-stream.
        do_reset();
        for (int t = 0; t < 4; t++) step(0, 0, 1, 8'(8'h71 + t), 1);
        step(1, 0, 1, 8'h99, 1);
        cmp("t5_rst_ready", 32'(c_ir), 32'd0);
        step(0, 0, 0, 8'h00, 1);
        cmp("t5_valid", 32'(c_ov),  32'd0);
        cmp("t5_data",  32'(c_od),  32'hA5);
        cmp("t5_count", 32'(c_cnt), 32'd0);
        for (int t = 0; t < 5; t++) step(0, 0, 0, 8'h00, 1);

        // Random traffic with occasional flush and reset.
        for (int t = 0; t < 10000; t++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 8'($urandom),
                 $urandom_range(0, 3) >= ((t / 1000) % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
